pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipelined ARM datapath (F/D/E/M/W). It drives the enable/clear controls of the inter-stage pipeline registers: stalls, flushes, operand-forwarding selects, and the stall window for the multi-cycle multiplier. It also keeps a saturating stall-cycle performance counter. It sits beside the datapath and observes only register addresses and control bits from each stage.

---
 rtl/pipe_hazard_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if
//   Bundles the signals between the 5-stage datapath and its hazard controller.
//   Inputs to the controller: decode/execute/memory/writeback register
//   addresses and control bits. Outputs: pipeline stall/flush enables,
//   forwarding selects, multiplier busy flag and the stall performance counter.
//   master : datapath side (drives stage info, receives controls)
//   slave  : controller side
interface pipe_hazard_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] d_ra1;
    logic [ADDR_W-1:0] d_ra2;
    logic [ADDR_W-1:0] e_ra1;
    logic [ADDR_W-1:0] e_ra2;
    logic [ADDR_W-1:0] e_wa;
    logic              e_regwrite;
    logic              e_memtoreg;
    logic              e_mul_start;
    logic              e_branch_taken;
    logic [ADDR_W-1:0] m_wa;
    logic              m_regwrite;
    logic [ADDR_W-1:0] w_wa;
    logic              w_regwrite;

    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mul_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output d_ra1, d_ra2, e_ra1, e_ra2, e_wa, e_regwrite, e_memtoreg,
               e_mul_start, e_branch_taken, m_wa, m_regwrite, w_wa, w_regwrite,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               fwd_a, fwd_b, mul_busy, stall_cnt
    );

    modport slave (
        input  d_ra1, d_ra2, e_ra1, e_ra2, e_wa, e_regwrite, e_memtoreg,
               e_mul_start, e_branch_taken, m_wa, m_regwrite, w_wa, w_regwrite,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               fwd_a, fwd_b, mul_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the F/D/E/M/W ARM pipeline.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - pipe_hazard_if.slave: stage addresses/controls in,
//             stall/flush/forward/mul_busy/stall_cnt out
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal flow: load-use stall, branch flush, multiply issue
//   MUL   | multiplier holds EX; F/D/E frozen, bubble injected into M
module pipe_hazard_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          reset,
    pipe_hazard_if.slave bus
);
    localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

    typedef enum logic {RUN, MUL} state_t;

    state_t            state_q, state_d;
    logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic       lu;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m, mul_busy;
    logic [1:0] fwd_a, fwd_b;

    assign lu = bus.e_memtoreg & bus.e_regwrite &
                ((bus.e_wa == bus.d_ra1) | (bus.e_wa == bus.d_ra2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        mul_busy  = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;

        // M-stage result is newer than W, so it wins; r15 is the PC and is
        // never taken from the bypass network.
        if (bus.m_regwrite && bus.m_wa == bus.e_ra1 && bus.e_ra1 != PC_REG)
            fwd_a = 2'b10;
        else if (bus.w_regwrite && bus.w_wa == bus.e_ra1 && bus.e_ra1 != PC_REG)
            fwd_a = 2'b01;

        if (bus.m_regwrite && bus.m_wa == bus.e_ra2 && bus.e_ra2 != PC_REG)
            fwd_b = 2'b10;
        else if (bus.w_regwrite && bus.w_wa == bus.e_ra2 && bus.e_ra2 != PC_REG)
            fwd_b = 2'b01;

        unique case (state_q)
            RUN: begin
                if (bus.e_branch_taken) begin
                    // Wrong-path instructions in F/D and D/E are discarded;
                    // any hazard they would have caused no longer matters.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else begin
                    if (bus.e_mul_start) begin
                        state_d   = MUL;
                        mul_cnt_d = MC_W'(MUL_LAT - 2);
                    end
                    if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            MUL: begin
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_e   = 1'b1;
                flush_m   = 1'b1;
                mul_busy  = 1'b1;
                mul_cnt_d = mul_cnt_q - MC_W'(1);
                if (mul_cnt_q == '0)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Controls drop the instant reset asserts, not at the next edge.
        if (reset) begin
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_e  = 1'b0;
            flush_d  = 1'b0;
            flush_e  = 1'b0;
            flush_m  = 1'b0;
            mul_busy = 1'b0;
            fwd_a    = 2'b00;
            fwd_b    = 2'b00;
        end
    end

    assign bus.stall_f   = stall_f;
    assign bus.stall_d   = stall_d;
    assign bus.stall_e   = stall_e;
    assign bus.flush_d   = flush_d;
    assign bus.flush_e   = flush_e;
    assign bus.flush_m   = flush_m;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.mul_busy  = mul_busy;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic clk;
    logic reset;

    pipe_hazard_if #(.ADDR_W(4), .CNT_W(16)) bus ();
    pipe_hazard_if #(.ADDR_W(4), .CNT_W(4))  bus_s ();

    pipe_hazard_ctrl #(.ADDR_W(4), .MUL_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    pipe_hazard_ctrl #(.ADDR_W(4), .MUL_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    assign bus_s.d_ra1          = bus.d_ra1;
    assign bus_s.d_ra2          = bus.d_ra2;
    assign bus_s.e_ra1          = bus.e_ra1;
    assign bus_s.e_ra2          = bus.e_ra2;
    assign bus_s.e_wa           = bus.e_wa;
    assign bus_s.e_regwrite     = bus.e_regwrite;
    assign bus_s.e_memtoreg     = bus.e_memtoreg;
    assign bus_s.e_mul_start    = bus.e_mul_start;
    assign bus_s.e_branch_taken = bus.e_branch_taken;
    assign bus_s.m_wa           = bus.m_wa;
    assign bus_s.m_regwrite     = bus.m_regwrite;
    assign bus_s.w_wa           = bus.w_wa;
    assign bus_s.w_regwrite     = bus.w_regwrite;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: stall_f stall_d stall_e flush_d flush_e flush_m mul_busy
    typedef struct {
        logic [3:0] d_ra1, d_ra2, e_ra1, e_ra2, e_wa;
        logic       e_rw, e_mtr, e_mul, e_br;
        logic [3:0] m_wa;
        logic       m_rw;
        logic [3:0] w_wa;
        logic       w_rw;
        logic [6:0] x_ctl;
        logic [1:0] x_fa, x_fb;
    } vec_t;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0001100;
    localparam logic [6:0] C_MUL  = 7'b1110011;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] ctl();
        return {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d,
                bus.flush_e, bus.flush_m, bus.mul_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.d_ra1 = v.d_ra1; bus.d_ra2 = v.d_ra2;
        bus.e_ra1 = v.e_ra1; bus.e_ra2 = v.e_ra2; bus.e_wa = v.e_wa;
        bus.e_regwrite = v.e_rw; bus.e_memtoreg = v.e_mtr;
        bus.e_mul_start = v.e_mul; bus.e_branch_taken = v.e_br;
        bus.m_wa = v.m_wa; bus.m_regwrite = v.m_rw;
        bus.w_wa = v.w_wa; bus.w_regwrite = v.w_rw;
    endtask

    task automatic idle();
        apply('{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                4'd0, 1'b0, 4'd0, 1'b0, C_NONE, 2'b00, 2'b00});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        #1;
    endtask

    vec_t vecs[14];
    int   exp_stalls;
    vec_t lu_v;

    initial begin
        reset = 1'b1;
        idle();
        vecs[0]  = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_NONE, 2'b00, 2'b00};
        vecs[1]  = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_LU,   2'b00, 2'b00};
        vecs[2]  = '{4'd8, 4'd2, 4'd4, 4'd6, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_LU,   2'b00, 2'b00};
        vecs[3]  = '{4'd8, 4'd2, 4'd4, 4'd6, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_NONE, 2'b00, 2'b00};
        vecs[4]  = '{4'd8, 4'd2, 4'd4, 4'd6, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_NONE, 2'b00, 2'b00};
        vecs[5]  = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, C_NONE, 2'b00, 2'b00};
        vecs[6]  = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, C_BR,   2'b00, 2'b00};
        vecs[7]  = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, C_BR,   2'b00, 2'b00};
        vecs[8]  = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, C_NONE, 2'b10, 2'b00};
        vecs[9]  = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 4'd5, 1'b1, C_NONE, 2'b01, 2'b00};
        vecs[10] = '{4'd1, 4'd2, 4'd15, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd15, 1'b1, C_NONE, 2'b00, 2'b00};
        vecs[11] = '{4'd1, 4'd2, 4'd2, 4'd7, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd7, 1'b1, C_NONE, 2'b10, 2'b01};
        vecs[12] = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 4'd4, 1'b1, C_NONE, 2'b10, 2'b10};
        vecs[13] = '{4'd1, 4'd2, 4'd3, 4'd15, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, C_NONE, 2'b00, 2'b00};
        lu_v     = vecs[1];

        // Reset state
        tick();
        reset = 1'b0;
        #1;
        chk("reset_ctl", 32'(ctl()), 32'(C_NONE));
        chk("reset_cnt", 32'(bus.stall_cnt), 0);

        // Table vectors, all in RUN
        exp_stalls = 0;
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].x_ctl));
            chk($sformatf("vec%0d_fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].x_fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].x_fb));
            if (vecs[i].x_ctl[6]) exp_stalls++;
            tick();
        end
        idle();
        #1;
        chk("table_cnt", 32'(bus.stall_cnt), 32'(exp_stalls));
        chk("after_branch_mul_run", 32'(ctl()), 32'(C_NONE));

        // Single load-use bubble
        do_reset();
        apply(lu_v);
        #1;
        chk("lu_ctl", 32'(ctl()), 32'(C_LU));
        tick();
        idle();
        #1;
        chk("lu_next_ctl", 32'(ctl()), 32'(C_NONE));
        chk("lu_cnt", 32'(bus.stall_cnt), 1);

        // Multiply, MUL_LAT=4: issue cycle then three frozen cycles
        do_reset();
        bus.e_mul_start = 1'b1;
        #1;
        chk("mul_issue_ctl", 32'(ctl()), 32'(C_NONE));
        for (int c = 1; c <= 3; c++) begin
            tick();
            apply(lu_v);
            bus.e_branch_taken = (c == 2);
            #1;
            chk($sformatf("mul_c%0d_ctl", c), 32'(ctl()), 32'(C_MUL));
        end
        tick();
        idle();
        #1;
        chk("mul_done_ctl", 32'(ctl()), 32'(C_NONE));
        chk("mul_cnt", 32'(bus.stall_cnt), 3);

        // Reset in the middle of a multiply
        do_reset();
        bus.e_mul_start = 1'b1;
        tick();
        bus.e_mul_start = 1'b0;
        tick();
        apply(lu_v);
        bus.e_ra1 = 4'd5; bus.m_wa = 4'd5; bus.m_regwrite = 1'b1;
        #1;
        chk("midmul_ctl", 32'(ctl()), 32'(C_MUL));
        chk("midmul_fwd_a", 32'(bus.fwd_a), 32'(2'b10));
        reset = 1'b1;
        #1;
        chk("async_rst_ctl", 32'(ctl()), 32'(C_NONE));
        chk("async_rst_fwd", 32'({bus.fwd_a, bus.fwd_b}), 0);
        chk("async_rst_cnt", 32'(bus.stall_cnt), 0);
        tick();
        reset = 1'b0;
        idle();
        tick();
        chk("post_rst_run", 32'(ctl()), 32'(C_NONE));
        chk("post_rst_cnt", 32'(bus.stall_cnt), 0);

        // Saturating counter: 20 stalled cycles
        do_reset();
        apply(lu_v);
        for (int c = 0; c < 20; c++) tick();
        chk("sat_cnt_w4", 32'(bus_s.stall_cnt), 15);
        chk("sat_cnt_w16", 32'(bus.stall_cnt), 20);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
